bus_wait_ctrl: RTL and testbench

//  Bus access sequencer between the CPU memory port and the four address regions.

---
 rtl/bus_wait_ctrl.sv | 138 +++++++++++++
 tb/tb_bus_wait_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_ctrl.sv
// Bus access sequencer between the CPU memory port and four address regions.
// Latency: ready pulses WAITn+1 edges after the accepted req edge; illegal CS answers after one edge.
// Backpressure: req is only sampled in IDLE (including the ready cycle); req while busy is ignored.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req, we, adresse, wdata  CPU request, direction, address and write data
//   CS0..CS3                 one-hot region selects from the address decoder
//   rdata0..rdata3           read data returned by regions 0..3
//   mem_adr, mem_wdata       registered address / write data to the regions
//   mem_we, mem_en           registered write strobe and one-hot region enable
//   rdata, ready, busy, err  registered read data, completion pulse, busy flag, illegal-CS pulse
module bus_wait_ctrl #(
    parameter int DATA_W = 16,
    parameter int WAIT0  = 0,
    parameter int WAIT1  = 1,
    parameter int WAIT2  = 2,
    parameter int WAIT3  = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [15:0]       adresse,
    input  logic [DATA_W-1:0] wdata,
    input  logic              CS0,
    input  logic              CS1,
    input  logic              CS2,
    input  logic              CS3,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] rdata3,
    output logic [15:0]       mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [3:0]        mem_en,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        cs_vec;
    logic              cs_onehot;
    logic [CNT_W-1:0]  wait_sel;
    logic [DATA_W-1:0] region_data;

    assign cs_vec    = {CS3, CS2, CS1, CS0};
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign cs_onehot = (cs_vec != 4'd0) && ((cs_vec & (cs_vec - 4'd1)) == 4'd0);
    assign busy      = (state == S_WAIT);

    always_comb begin
        wait_sel = '0;
        case (cs_vec)
            4'b0001: wait_sel = CNT_W'(WAIT0);
            4'b0010: wait_sel = CNT_W'(WAIT1);
            4'b0100: wait_sel = CNT_W'(WAIT2);
            4'b1000: wait_sel = CNT_W'(WAIT3);
            default: wait_sel = '0;
        endcase
    end

    // Read data is selected by the latched enable so the CS inputs may move mid-access.
    always_comb begin
        region_data = '0;
        case (mem_en)
            4'b0001: region_data = rdata0;
            4'b0010: region_data = rdata1;
            4'b0100: region_data = rdata2;
            4'b1000: region_data = rdata3;
            default: region_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_en    <= 4'd0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        mem_adr   <= adresse;
                        mem_wdata <= wdata;
                        mem_we    <= we;
                        if (cs_onehot) begin
                            mem_en <= cs_vec;
                            cnt    <= wait_sel;
                            state  <= S_WAIT;
                        end else begin
                            // No region to talk to: complete at once and flag it.
                            mem_en <= 4'd0;
                            ready  <= 1'b1;
                            err    <= 1'b1;
                            rdata  <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!mem_we) begin
                            rdata <= region_data;
                        end
                        mem_en <= 4'd0;
                        mem_we <= 1'b0;
                        ready  <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    mem_en <= 4'd0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
module tb_bus_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [15:0] adresse = '0;
    logic [15:0] wdata = '0;
    logic        CS0 = 1'b0, CS1 = 1'b0, CS2 = 1'b0, CS3 = 1'b0;
    logic [15:0] rdata0 = '0, rdata1 = '0, rdata2 = '0, rdata3 = '0;
    logic [15:0] mem_adr, mem_wdata, rdata;
    logic        mem_we, ready, busy, err;
    logic [3:0]  mem_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_wait_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .adresse(adresse), .wdata(wdata),
        .CS0(CS0), .CS1(CS1), .CS2(CS2), .CS3(CS3),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_cs(input logic [3:0] v);
        {CS3, CS2, CS1, CS0} = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (mem_en !== 4'd0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0000", mem_en); end
        checks++; if ({ready, busy, err, mem_we} !== 4'd0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {ready, busy, err, mem_we}); end
        checks++; if ({mem_adr, mem_wdata, rdata} !== 48'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {mem_adr, mem_wdata, rdata}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_r0();
        adresse = 16'h1234; we = 1'b0; rdata0 = 16'hBEEF; set_cs(4'b0001); req = 1'b1;
        step();
        checks++; if (mem_en !== 4'b0001) begin errors++; $display("FAIL rd0_mem_en got=%b exp=0001", mem_en); end
        checks++; if (mem_adr !== 16'h1234) begin errors++; $display("FAIL rd0_mem_adr got=%h exp=1234", mem_adr); end
        checks++; if ({busy, ready} !== 2'b10) begin errors++; $display("FAIL rd0_busy_ready got=%b exp=10", {busy, ready}); end
        // Inputs move after the req edge; the access must not notice.
        req = 1'b0; adresse = 16'hFFFF; set_cs(4'b0000);
        step();
        checks++; if ({ready, err, busy} !== 3'b100) begin errors++; $display("FAIL rd0_ready got=%b exp=100", {ready, err, busy}); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL rd0_rdata got=%h exp=beef", rdata); end
        checks++; if (mem_en !== 4'd0) begin errors++; $display("FAIL rd0_en_clear got=%b exp=0000", mem_en); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rd0_ready_pulse got=%b exp=0", ready); end
    endtask

    task automatic test_write_r3();
        adresse = 16'hC010; wdata = 16'h55AA; we = 1'b1; rdata3 = 16'h7777; set_cs(4'b1000); req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            req = 1'b0; we = 1'b0; wdata = 16'h0000; set_cs(4'b0000);
            checks++; if ({mem_en, mem_we, ready} !== 6'b1000_1_0) begin errors++; $display("FAIL wr3_hold_%0d got=%b exp=100010", k, {mem_en, mem_we, ready}); end
        end
        checks++; if ({mem_adr, mem_wdata} !== {16'hC010, 16'h55AA}) begin errors++; $display("FAIL wr3_regs got=%h exp=c01055aa", {mem_adr, mem_wdata}); end
        step();
        checks++; if ({ready, mem_en, mem_we} !== 6'b1_0000_0) begin errors++; $display("FAIL wr3_done got=%b exp=100000", {ready, mem_en, mem_we}); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL wr3_rdata_kept got=%h exp=beef", rdata); end
    endtask

    task automatic test_back_to_back();
        adresse = 16'h4000; we = 1'b0; rdata1 = 16'h1111; rdata2 = 16'h2222; set_cs(4'b0010); req = 1'b1;
        step();
        req = 1'b0;
        checks++; if ({mem_en, ready} !== 5'b0010_0) begin errors++; $display("FAIL b2b_first_en got=%b exp=00100", {mem_en, ready}); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_first_early got=%b exp=0", ready); end
        step();
        checks++; if ({ready, rdata} !== {1'b1, 16'h1111}) begin errors++; $display("FAIL b2b_first_done got=%h exp=11111", {ready, rdata}); end
        // Issue the second request in the ready cycle.
        adresse = 16'h8000; set_cs(4'b0100); req = 1'b1;
        step();
        req = 1'b0;
        checks++; if ({mem_en, ready, mem_adr} !== {4'b0100, 1'b0, 16'h8000}) begin errors++; $display("FAIL b2b_second_en got=%h exp=88000", {mem_en, ready, mem_adr}); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_early1 got=%b exp=0", ready); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_early2 got=%b exp=0", ready); end
        step();
        checks++; if ({ready, rdata} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL b2b_second_done got=%h exp=12222", {ready, rdata}); end
    endtask

    task automatic test_illegal_cs();
        logic [3:0] pats [2];
        pats[0] = 4'b0000; pats[1] = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            adresse = 16'h5555; we = 1'b0; set_cs(pats[i]); req = 1'b1;
            step();
            req = 1'b0;
            checks++; if ({ready, err, busy, mem_en} !== 7'b110_0000) begin errors++; $display("FAIL illegal_%0d got=%b exp=1100000", i, {ready, err, busy, mem_en}); end
            checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL illegal_rdata_%0d got=%h exp=0000", i, rdata); end
            step();
            checks++; if ({ready, err} !== 2'b00) begin errors++; $display("FAIL illegal_pulse_%0d got=%b exp=00", i, {ready, err}); end
        end
    endtask

    task automatic test_reset_mid_access();
        int rdy_seen;
        adresse = 16'hC000; we = 1'b0; rdata3 = 16'h3333; set_cs(4'b1000); req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        // Counter now 2 (4 loaded, two decrements).
        checks++; if ({busy, mem_en} !== 5'b1_1000) begin errors++; $display("FAIL rstmid_pre got=%b exp=11000", {busy, mem_en}); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_en, mem_we, ready, busy, err} !== 8'd0) begin errors++; $display("FAIL rstmid_flags got=%b exp=00000000", {mem_en, mem_we, ready, busy, err}); end
        checks++; if ({mem_adr, mem_wdata, rdata} !== 48'd0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", {mem_adr, mem_wdata, rdata}); end
        step();
        rst = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ready) rdy_seen++;
        end
        checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL rstmid_no_ready got=%0d exp=0", rdy_seen); end
        adresse = 16'h0100; rdata0 = 16'h0A0A; set_cs(4'b0001); req = 1'b1;
        step();
        req = 1'b0;
        checks++; if (mem_en !== 4'b0001) begin errors++; $display("FAIL rstmid_next_en got=%b exp=0001", mem_en); end
        step();
        checks++; if ({ready, rdata} !== {1'b1, 16'h0A0A}) begin errors++; $display("FAIL rstmid_next_done got=%h exp=10a0a", {ready, rdata}); end
    endtask

    task automatic test_req_held();
        int rdy_seen;
        bit got;
        adresse = 16'h8888; we = 1'b0; rdata2 = 16'h4242; set_cs(4'b0100); req = 1'b1;
        rdy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ready) rdy_seen++;
            checks++; if ({busy, mem_en} !== 5'b1_0100) begin errors++; $display("FAIL held_busy_%0d got=%b exp=10100", k, {busy, mem_en}); end
        end
        checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL held_early_ready got=%0d exp=0", rdy_seen); end
        step();
        checks++; if ({ready, rdata, mem_en} !== {1'b1, 16'h4242, 4'b0000}) begin errors++; $display("FAIL held_done got=%h exp=84242 en0", {ready, rdata, mem_en}); end
        // req is still high in the ready cycle, so a second access starts on this edge.
        step();
        req = 1'b0;
        checks++; if ({busy, mem_en, ready} !== 6'b1_0100_0) begin errors++; $display("FAIL held_restart got=%b exp=101000", {busy, mem_en, ready}); end
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (ready) got = 1'b1;
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL held_second_timeout got=%b exp=1", got); end
        step();
        checks++; if ({busy, mem_en, ready} !== 6'd0) begin errors++; $display("FAIL held_idle got=%b exp=000000", {busy, mem_en, ready}); end
    endtask

    initial begin
        test_reset();
        test_read_r0();
        test_write_r3();
        test_back_to_back();
        test_illegal_cs();
        test_reset_mid_access();
        test_req_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
